// File: rtl/note_scheduler_if.sv
// Note offer handshake between the chart scheduler and the display/judge stage.
interface note_scheduler_if;
   logic        note_valid;
   logic        note_ready;
   logic [15:0] note_time;
   logic [4:0]  note_lanes;

   modport master (
      output note_valid,
      output note_time,
      output note_lanes,
      input  note_ready
   );

   modport slave (
      input  note_valid,
      input  note_time,
      input  note_lanes,
      output note_ready
   );
endinterface

// File: rtl/note_scheduler.sv
// Walks the chart ROM and offers each note LEAD ticks ahead of its hit time.
// Optional SCHED_SKIP_LATE_EN drops already-late entries instead of offering them.
module note_scheduler #(
   parameter int ADDR_W = 10,
   parameter int LEAD   = 200
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [15:0]       song_time,
   input  logic              song_restart,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [23:0]       rom_data,
   note_scheduler_if.master  note,
   output logic              done,
   output logic              late,
   output logic [7:0]        skip_count
);

   typedef enum logic [2:0] {
      FETCH,
      WAIT,
      HOLD,
      OFFER,
      DONE
   } state_t;

   state_t state, state_n;

   logic [15:0] ent_time;
   logic        ent_end;
   logic [4:0]  ent_lanes;

   logic        valid_q;
   logic [15:0] time_q;
   logic [4:0]  lanes_q;

   logic cap, adv, offer, accept, skip;
   logic emit, is_late, last_addr;
   logic unused_rsvd;

   assign unused_rsvd = ^rom_data[6:5];

   // 17-bit sum so a look-ahead past 65535 never wraps around
   assign emit = ({1'b0, song_time} + 17'(LEAD)) >= {1'b0, ent_time};
   assign is_late   = ent_time < song_time;
   assign last_addr = &rom_addr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= FETCH;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      cap     = 1'b0;
      adv     = 1'b0;
      offer   = 1'b0;
      accept  = 1'b0;
      skip    = 1'b0;
      unique case (state)
         FETCH: state_n = WAIT;
         WAIT: begin
            cap     = 1'b1;
            state_n = HOLD;
         end
         HOLD: begin
            if (ent_end) begin
               state_n = DONE;
            end else if (ent_lanes == 5'd0) begin
               adv = 1'b1;
            end else if (emit) begin
`ifdef SCHED_SKIP_LATE_EN
               if (is_late) begin
                  skip = 1'b1;
                  adv  = 1'b1;
               end else begin
                  offer   = 1'b1;
                  state_n = OFFER;
               end
`else
               offer   = 1'b1;
               state_n = OFFER;
`endif
            end
         end
         OFFER: begin
            if (note.note_ready) begin
               accept = 1'b1;
               adv    = 1'b1;
            end
         end
         DONE: state_n = DONE;
         default: state_n = FETCH;
      endcase
      // the last ROM slot ends the chart rather than wrapping to 0
      if (adv)
         state_n = last_addr ? DONE : FETCH;
      if (song_restart)
         state_n = FETCH;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_addr  <= '0;
         ent_time  <= '0;
         ent_end   <= 1'b0;
         ent_lanes <= '0;
         valid_q   <= 1'b0;
         time_q    <= '0;
         lanes_q   <= '0;
         late      <= 1'b0;
      end else if (song_restart) begin
         rom_addr <= '0;
         valid_q  <= 1'b0;
         late     <= 1'b0;
      end else begin
         if (cap) begin
            ent_time  <= rom_data[23:8];
            ent_end   <= rom_data[7];
            ent_lanes <= rom_data[4:0];
         end
         if (adv && !last_addr)
            rom_addr <= rom_addr + 1'b1;
         if (offer) begin
            valid_q <= 1'b1;
            time_q  <= ent_time;
            lanes_q <= ent_lanes;
            if (is_late)
               late <= 1'b1;
         end
         if (accept)
            valid_q <= 1'b0;
      end
   end

`ifdef SCHED_SKIP_LATE_EN
   logic [7:0] skip_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         skip_q <= '0;
      else if (song_restart)
         skip_q <= '0;
      else if (skip && skip_q != 8'hFF)
         skip_q <= skip_q + 8'd1;
   end

   assign skip_count = skip_q;
`else
   logic unused_skip;
   assign unused_skip = skip;
   assign skip_count  = 8'd0;
`endif

   assign done            = (state == DONE);
   assign note.note_valid = valid_q;
   assign note.note_time  = time_q;
   assign note.note_lanes = lanes_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler on an 8-entry chart ROM.
// Expectations follow SCHED_SKIP_LATE_EN when the bench is built with it.
module tb_note_scheduler;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          song_restart = 1'b0;
   logic [15:0]   song_time = 16'd0;
   logic [AW-1:0] rom_addr;
   logic [23:0]   rom_data = 24'd0;
   logic          done;
   logic          late;
   logic [7:0]    skip_count;

   logic [23:0] rom [8];

   int n_cmp = 0;
   int n_err = 0;

   int          exp_gap [7] = '{3, 4, 4, 7, 4, 4, 4};
   logic [15:0] exp_t   [7] = '{16'd65400, 16'd65450, 16'd65500, 16'd65500,
                                16'd65500, 16'd65500, 16'd65500};
   logic [4:0]  exp_l   [7] = '{5'd1, 5'd2, 5'd8, 5'd16, 5'd1, 5'd2, 5'd4};

   note_scheduler_if nif ();

   note_scheduler #(
      .ADDR_W (AW),
      .LEAD   (200)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .song_time    (song_time),
      .song_restart (song_restart),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .note         (nif.master),
      .done         (done),
      .late         (late),
      .skip_count   (skip_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   function automatic logic [23:0] ent(input logic [15:0] t,
                                       input logic [4:0] l,
                                       input logic e);
      return {t, e, 2'b00, l};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic restart;
      song_restart = 1'b1;
      tick();
      song_restart = 1'b0;
   endtask

   task automatic clear_rom;
      for (int i = 0; i < 8; i++) rom[i] = ent(16'd0, 5'd0, 1'b1);
   endtask

   task automatic wait_valid(input int maxc, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!nif.note_valid && n < maxc);
   endtask

   initial begin
      int n;
      logic ok;
      logic seen;

      nif.note_ready = 1'b1;
      clear_rom();
      rom[0] = ent(16'd300, 5'b00001, 1'b0);
      rom[1] = ent(16'd300, 5'b00010, 1'b0);
      song_time = 16'd100;

      tick();
      tick();
      chk("rst_addr", rom_addr, 0);
      chk("rst_valid", nif.note_valid, 0);
      chk("rst_time", nif.note_time, 0);
      chk("rst_lanes", nif.note_lanes, 0);
      chk("rst_done", done, 0);
      chk("rst_late", late, 0);
      chk("rst_skip", skip_count, 0);

      // two notes back-to-back, then chart end
      reset_n = 1'b1;
      wait_valid(12, n);
      chk("b2b_lat0", n, 3);
      chk("b2b_v0", nif.note_valid, 1);
      chk("b2b_t0", nif.note_time, 300);
      chk("b2b_l0", nif.note_lanes, 1);
      wait_valid(12, n);
      chk("b2b_gap", n, 4);
      chk("b2b_l1", nif.note_lanes, 2);
      chk("b2b_t1", nif.note_time, 300);
      repeat (4) tick();
      chk("b2b_done", done, 1);
      chk("b2b_vend", nif.note_valid, 0);
      chk("b2b_late", late, 0);

      // emit threshold and long backpressure
      nif.note_ready = 1'b0;
      clear_rom();
      rom[0] = ent(16'd500, 5'b10000, 1'b0);
      song_time = 16'd299;
      restart();
      chk("rs_done", done, 0);
      repeat (10) tick();
      chk("thr_299", nif.note_valid, 0);
      song_time = 16'd300;
      tick();
      chk("thr_300", nif.note_valid, 1);
      chk("thr_t", nif.note_time, 500);
      chk("thr_l", nif.note_lanes, 16);
      ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (nif.note_valid !== 1'b1 || nif.note_time !== 16'd500 ||
             nif.note_lanes !== 5'd16 || rom_addr !== 3'd0)
            ok = 1'b0;
      end
      chk("bp_stable", ok, 1);
      nif.note_ready = 1'b1;
      tick();
      nif.note_ready = 1'b0;
      chk("bp_acc_v", nif.note_valid, 0);
      chk("bp_acc_a", rom_addr, 1);
      repeat (3) tick();
      chk("bp_done", done, 1);

      // restart beats ready on a pending offer
      clear_rom();
      rom[0] = ent(16'd300, 5'b00001, 1'b0);
      rom[1] = ent(16'd300, 5'b00010, 1'b0);
      song_time = 16'd100;
      restart();
      wait_valid(12, n);
      chk("rp_lat", n, 3);
      song_restart = 1'b1;
      nif.note_ready = 1'b1;
      tick();
      song_restart = 1'b0;
      nif.note_ready = 1'b0;
      chk("rp_valid", nif.note_valid, 0);
      chk("rp_addr", rom_addr, 0);
      chk("rp_done", done, 0);
      wait_valid(12, n);
      chk("rp_relat", n, 3);
      chk("rp_l", nif.note_lanes, 1);

      // late entry
      clear_rom();
      rom[0] = ent(16'd50, 5'b00100, 1'b0);
      song_time = 16'd80;
      restart();
`ifdef SCHED_SKIP_LATE_EN
      seen = 1'b0;
      repeat (8) begin
         tick();
         seen = seen | nif.note_valid;
      end
      chk("sk_noofr", seen, 0);
      chk("sk_count", skip_count, 1);
      chk("sk_late", late, 0);
      chk("sk_done", done, 1);
`else
      seen = 1'b0;
      wait_valid(12, n);
      chk("lt_lat", n, 3);
      chk("lt_l", nif.note_lanes, 4);
      chk("lt_late", late, 1);
      chk("lt_skip", skip_count, 0);
      nif.note_ready = 1'b1;
      tick();
      nif.note_ready = 1'b0;
      chk("lt_sticky", late, 1);
`endif
      restart();
      chk("rs_late", late, 0);
      chk("rs_skip", skip_count, 0);

      // zero-lane skip, top-of-range times, last-address end
      clear_rom();
      rom[0] = ent(16'd65400, 5'd1, 1'b0);
      rom[1] = ent(16'd65450, 5'd2, 1'b0);
      rom[2] = ent(16'd65500, 5'd8, 1'b0);
      rom[3] = ent(16'd100, 5'd0, 1'b0);
      rom[4] = ent(16'd65500, 5'd16, 1'b0);
      rom[5] = ent(16'd65500, 5'd1, 1'b0);
      rom[6] = ent(16'd65500, 5'd2, 1'b0);
      rom[7] = ent(16'd65500, 5'd4, 1'b0);
      song_time = 16'd65400;
      nif.note_ready = 1'b1;
      restart();
      for (int k = 0; k < 7; k++) begin
         wait_valid(16, n);
         chk($sformatf("hi_gap%0d", k), n, exp_gap[k]);
         chk($sformatf("hi_t%0d", k), nif.note_time, exp_t[k]);
         chk($sformatf("hi_l%0d", k), nif.note_lanes, exp_l[k]);
      end
      tick();
      chk("end_done", done, 1);
      chk("end_addr", rom_addr, 7);
      chk("end_valid", nif.note_valid, 0);
      repeat (5) tick();
      chk("end_hold", done, 1);
      chk("end_addr2", rom_addr, 7);
      chk("end_late", late, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
